pixel_adjust_stage: RTL and testbench

PIXEL_ADJUST_STAGE -- requirements
Module: pixel_adjust_stage

---
 rtl/pixel_adjust_stage_if.sv | 23 ++
 rtl/pixel_adjust_stage.sv | 219 +++++++++++++++++++++
 tb/tb_pixel_adjust_stage.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_adjust_stage_if.sv
// Pixel stream bundle for pixel_adjust_stage: raster input pixels in, tagged adjusted pixels out.
interface pixel_adjust_stage_if;
  logic        IN_VALID;
  logic [7:0]  IN_RED;
  logic [7:0]  IN_GREEN;
  logic [7:0]  IN_BLUE;
  logic        OUT_VALID;
  logic [11:0] ROW;
  logic [11:0] COL;
  logic [7:0]  RED;
  logic [7:0]  GREEN;
  logic [7:0]  BLUE;

  modport master (
    output IN_VALID, IN_RED, IN_GREEN, IN_BLUE,
    input  OUT_VALID, ROW, COL, RED, GREEN, BLUE
  );

  modport slave (
    input  IN_VALID, IN_RED, IN_GREEN, IN_BLUE,
    output OUT_VALID, ROW, COL, RED, GREEN, BLUE
  );
endinterface

// File: rtl/pixel_adjust_stage.sv
// Frame pixel brightness adjust: raster position tagging plus a two-stage saturating add/subtract pipeline.
// Defining PIXEL_ADJUST_GRAYSCALE_EN adds the GRAY_MODE port and a luma conversion ahead of the adjust.
module pixel_adjust_stage #(
  parameter int MAX_WIDTH  = 1080,
  parameter int MAX_HEIGHT = 1080
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [11:0] WIDTH,
  input  logic [11:0] HEIGHT,
  input  logic [7:0]  ADJ_VALUE,
  input  logic        ADJ_SUB,
`ifdef PIXEL_ADJUST_GRAYSCALE_EN
  input  logic        GRAY_MODE,
`endif
  output logic        BUSY,
  output logic        FRAME_DONE,
  pixel_adjust_stage_if.slave pix
);

  localparam logic [11:0] MAX_W = 12'(MAX_WIDTH);
  localparam logic [11:0] MAX_H = 12'(MAX_HEIGHT);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t      state_q, state_d;
  logic [11:0] w_q, w_d, h_q, h_d, row_q, row_d, col_q, col_d;
  logic        busy_q, busy_d, frame_done_q, frame_done_d;

  logic        s1_valid_q, s1_valid_d, s1_last_q, s1_last_d, s1_sub_q, s1_sub_d;
  logic [7:0]  s1_red_q, s1_red_d, s1_green_q, s1_green_d, s1_blue_q, s1_blue_d;
  logic [7:0]  s1_adj_q, s1_adj_d;
  logic [11:0] s1_row_q, s1_row_d, s1_col_q, s1_col_d;
`ifdef PIXEL_ADJUST_GRAYSCALE_EN
  logic        s1_gray_q, s1_gray_d;
  logic [9:0]  luma_sum;
`endif

  logic        out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [11:0] out_row_q, out_row_d, out_col_q, out_col_d;
  logic [7:0]  out_red_q, out_red_d, out_green_q, out_green_d, out_blue_q, out_blue_d;

  logic        accept, last_pixel;
  logic [7:0]  src_red, src_green, src_blue;

  // 9-bit intermediate: bit 8 flags overflow on add and borrow on subtract.
  function automatic logic [7:0] adjust(input logic [7:0] c, input logic [7:0] adj, input logic sub);
    logic [8:0] res;
    res = sub ? ({1'b0, c} - {1'b0, adj}) : ({1'b0, c} + {1'b0, adj});
    if (res[8]) return sub ? 8'h00 : 8'hFF;
    return res[7:0];
  endfunction

  assign accept     = (state_q == RUN) && pix.IN_VALID;
  assign last_pixel = (row_q == h_q - 12'd1) && (col_q == w_q - 12'd1);

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    h_d     = h_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      IDLE: begin
        if (START && (WIDTH != 12'd0) && (HEIGHT != 12'd0)) begin
          state_d = RUN;
          w_d     = (WIDTH > MAX_W) ? MAX_W : WIDTH;
          h_d     = (HEIGHT > MAX_H) ? MAX_H : HEIGHT;
          row_d   = 12'd0;
          col_d   = 12'd0;
        end
      end
      RUN: begin
        if (accept) begin
          if (last_pixel) begin
            state_d = FLUSH;
          end else if (col_q == w_q - 12'd1) begin
            col_d = 12'd0;
            row_d = row_q + 12'd1;
          end else begin
            col_d = col_q + 12'd1;
          end
        end
      end
      FLUSH: begin
        if (out_valid_q && out_last_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d       = (state_d == RUN) || (state_d == FLUSH);
    frame_done_d = (state_d == DONE);
  end

  // Stage 1 captures the pixel, its position and the adjust setting in effect at acceptance.
  always_comb begin
    s1_valid_d = accept;
    s1_last_d  = accept && last_pixel;
    s1_red_d   = s1_red_q;
    s1_green_d = s1_green_q;
    s1_blue_d  = s1_blue_q;
    s1_adj_d   = s1_adj_q;
    s1_sub_d   = s1_sub_q;
    s1_row_d   = s1_row_q;
    s1_col_d   = s1_col_q;
`ifdef PIXEL_ADJUST_GRAYSCALE_EN
    s1_gray_d  = s1_gray_q;
`endif
    if (accept) begin
      s1_red_d   = pix.IN_RED;
      s1_green_d = pix.IN_GREEN;
      s1_blue_d  = pix.IN_BLUE;
      s1_adj_d   = ADJ_VALUE;
      s1_sub_d   = ADJ_SUB;
      s1_row_d   = row_q;
      s1_col_d   = col_q;
`ifdef PIXEL_ADJUST_GRAYSCALE_EN
      s1_gray_d  = GRAY_MODE;
`endif
    end
  end

  always_comb begin
    out_valid_d = s1_valid_q;
    out_last_d  = s1_valid_q && s1_last_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    out_red_d   = out_red_q;
    out_green_d = out_green_q;
    out_blue_d  = out_blue_q;
    src_red     = s1_red_q;
    src_green   = s1_green_q;
    src_blue    = s1_blue_q;
`ifdef PIXEL_ADJUST_GRAYSCALE_EN
    luma_sum = {2'b00, s1_red_q} + {1'b0, s1_green_q, 1'b0} + {2'b00, s1_blue_q};
    if (s1_gray_q) begin
      src_red   = luma_sum[9:2];
      src_green = luma_sum[9:2];
      src_blue  = luma_sum[9:2];
    end
`endif
    if (s1_valid_q) begin
      out_row_d   = s1_row_q;
      out_col_d   = s1_col_q;
      out_red_d   = adjust(src_red,   s1_adj_q, s1_sub_q);
      out_green_d = adjust(src_green, s1_adj_q, s1_sub_q);
      out_blue_d  = adjust(src_blue,  s1_adj_q, s1_sub_q);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= IDLE;
      w_q          <= '0;
      h_q          <= '0;
      row_q        <= '0;
      col_q        <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_sub_q     <= 1'b0;
      s1_red_q     <= '0;
      s1_green_q   <= '0;
      s1_blue_q    <= '0;
      s1_adj_q     <= '0;
      s1_row_q     <= '0;
      s1_col_q     <= '0;
`ifdef PIXEL_ADJUST_GRAYSCALE_EN
      s1_gray_q    <= 1'b0;
`endif
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      out_red_q    <= '0;
      out_green_q  <= '0;
      out_blue_q   <= '0;
    end else begin
      state_q      <= state_d;
      w_q          <= w_d;
      h_q          <= h_d;
      row_q        <= row_d;
      col_q        <= col_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      s1_valid_q   <= s1_valid_d;
      s1_last_q    <= s1_last_d;
      s1_sub_q     <= s1_sub_d;
      s1_red_q     <= s1_red_d;
      s1_green_q   <= s1_green_d;
      s1_blue_q    <= s1_blue_d;
      s1_adj_q     <= s1_adj_d;
      s1_row_q     <= s1_row_d;
      s1_col_q     <= s1_col_d;
`ifdef PIXEL_ADJUST_GRAYSCALE_EN
      s1_gray_q    <= s1_gray_d;
`endif
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      out_red_q    <= out_red_d;
      out_green_q  <= out_green_d;
      out_blue_q   <= out_blue_d;
    end
  end

  assign BUSY          = busy_q;
  assign FRAME_DONE    = frame_done_q;
  assign pix.OUT_VALID = out_valid_q;
  assign pix.ROW       = out_row_q;
  assign pix.COL       = out_col_q;
  assign pix.RED       = out_red_q;
  assign pix.GREEN     = out_green_q;
  assign pix.BLUE      = out_blue_q;

endmodule

// File: tb/tb_pixel_adjust_stage.sv
// Directed bench for pixel_adjust_stage with a scoreboard of expected output pixels.
// Build with PIXEL_ADJUST_GRAYSCALE_EN defined to also cover the grayscale path.
module tb_pixel_adjust_stage;
  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic [11:0] WIDTH;
  logic [11:0] HEIGHT;
  logic [7:0]  ADJ_VALUE;
  logic        ADJ_SUB;
`ifdef PIXEL_ADJUST_GRAYSCALE_EN
  logic        GRAY_MODE;
`endif
  logic        BUSY;
  logic        FRAME_DONE;

  pixel_adjust_stage_if pix ();

  // Small maximum dimensions so that clamping can be exercised with short frames.
  pixel_adjust_stage #(.MAX_WIDTH(4), .MAX_HEIGHT(4)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .START      (START),
    .WIDTH      (WIDTH),
    .HEIGHT     (HEIGHT),
    .ADJ_VALUE  (ADJ_VALUE),
    .ADJ_SUB    (ADJ_SUB),
`ifdef PIXEL_ADJUST_GRAYSCALE_EN
    .GRAY_MODE  (GRAY_MODE),
`endif
    .BUSY       (BUSY),
    .FRAME_DONE (FRAME_DONE),
    .pix        (pix)
  );

  typedef struct {
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic [11:0] row;
    logic [11:0] col;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int out_cnt = 0;
  int frame_done_cnt = 0;
  int last_out_cyc = -1;
  int frame_done_cyc = -1;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] modelAdjust(input int c, input int adj, input logic sub);
    int v;
    v = sub ? (c - adj) : (c + adj);
    if (v < 0)   v = 0;
    if (v > 255) v = 255;
    return 8'(v);
  endfunction

  // Output monitor: every OUT_VALID must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RESET === 1'b1) begin
        if (pix.OUT_VALID === 1'b1) begin
          out_cnt++;
          last_out_cyc = cyc;
          if (sb.size() == 0) begin
            checkOutput("unexpected_out_valid", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            checkOutput("red",     32'(pix.RED),   32'(e.red));
            checkOutput("green",   32'(pix.GREEN), 32'(e.green));
            checkOutput("blue",    32'(pix.BLUE),  32'(e.blue));
            checkOutput("row",     32'(pix.ROW),   32'(e.row));
            checkOutput("col",     32'(pix.COL),   32'(e.col));
            checkOutput("latency", 32'(cyc),       32'(e.cyc));
          end
        end
        if (FRAME_DONE === 1'b1) begin
          frame_done_cnt++;
          frame_done_cyc = cyc;
        end
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic acc, input int r, input int g, input int b,
                               input int adj, input logic sub, input int row, input int col);
    exp_t e;
    int er, eg, eb;
    @(negedge CLK);
    pix.IN_VALID = v;
    pix.IN_RED   = 8'(r);
    pix.IN_GREEN = 8'(g);
    pix.IN_BLUE  = 8'(b);
    ADJ_VALUE    = 8'(adj);
    ADJ_SUB      = sub;
    er = r;
    eg = g;
    eb = b;
`ifdef PIXEL_ADJUST_GRAYSCALE_EN
    if (GRAY_MODE) begin
      er = (r + 2 * g + b) / 4;
      eg = er;
      eb = er;
    end
`endif
    if (v && acc) begin
      e.red   = modelAdjust(er, adj, sub);
      e.green = modelAdjust(eg, adj, sub);
      e.blue  = modelAdjust(eb, adj, sub);
      e.row   = 12'(row);
      e.col   = 12'(col);
      e.cyc   = cyc + 2;
      sb.push_back(e);
    end
  endtask

  task automatic startFrame(input int w, input int h, input logic exp_busy, input string tag);
    @(negedge CLK);
    START  = 1'b1;
    WIDTH  = 12'(w);
    HEIGHT = 12'(h);
    @(posedge CLK);
    #1;
    START = 1'b0;
    checkOutput({tag, "_busy_after_start"}, 32'(BUSY), 32'(exp_busy));
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge CLK);
      pix.IN_VALID = 1'b0;
    end
    #1;
  endtask

  // Scrambles ADJ inputs while waiting so late sampling of the adjust setting shows up.
  task automatic waitFrameDone(input string tag);
    int base;
    int n;
    base = frame_done_cnt;
    n = 0;
    while (frame_done_cnt == base && n < 80) begin
      @(negedge CLK);
      pix.IN_VALID = 1'b0;
      ADJ_VALUE    = 8'hA5;
      ADJ_SUB      = ~ADJ_SUB;
      #1;
      n++;
    end
    checkOutput({tag, "_frame_done_seen"}, 32'(frame_done_cnt - base), 32'd1);
    checkOutput({tag, "_done_after_last_out"}, 32'(frame_done_cyc - last_out_cyc), 32'd1);
    checkOutput({tag, "_scoreboard_empty"}, 32'(sb.size()), 32'd0);
    idleCycles(3);
    checkOutput({tag, "_frame_done_single_pulse"}, 32'(frame_done_cnt - base), 32'd1);
    checkOutput({tag, "_busy_after_done"}, 32'(BUSY), 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_out_valid"},  32'(pix.OUT_VALID), 32'd0);
    checkOutput({tag, "_row"},        32'(pix.ROW),       32'd0);
    checkOutput({tag, "_col"},        32'(pix.COL),       32'd0);
    checkOutput({tag, "_red"},        32'(pix.RED),       32'd0);
    checkOutput({tag, "_green"},      32'(pix.GREEN),     32'd0);
    checkOutput({tag, "_blue"},       32'(pix.BLUE),      32'd0);
    checkOutput({tag, "_busy"},       32'(BUSY),          32'd0);
    checkOutput({tag, "_frame_done"}, 32'(FRAME_DONE),    32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog_timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int oc;
    int fd;
    RESET        = 1'b0;
    START        = 1'b0;
    WIDTH        = '0;
    HEIGHT       = '0;
    ADJ_VALUE    = '0;
    ADJ_SUB      = 1'b0;
    pix.IN_VALID = 1'b0;
    pix.IN_RED   = '0;
    pix.IN_GREEN = '0;
    pix.IN_BLUE  = '0;
`ifdef PIXEL_ADJUST_GRAYSCALE_EN
    GRAY_MODE    = 1'b0;
`endif
    #1;
    checkResetOutputs("reset");
    repeat (2) @(negedge CLK);
    RESET = 1'b1;

    $display("[TB] 4x2 frame, pass-through");
    startFrame(4, 2, 1'b1, "pass");
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, 1'b1, int'($urandom_range(255)), int'($urandom_range(255)),
                    int'($urandom_range(255)), 0, 1'b0, i / 4, i % 4);
    waitFrameDone("pass");

    $display("[TB] saturating add and subtract");
    startFrame(2, 1, 1'b1, "sat");
    applyStimulus(1'b1, 1'b1, 250, 10, 128, 10, 1'b0, 0, 0);
    applyStimulus(1'b1, 1'b1, 250, 10, 128, 10, 1'b1, 0, 1);
    waitFrameDone("sat");

    $display("[TB] stalled input 1,0,0,1,1");
    oc = out_cnt;
    startFrame(3, 1, 1'b1, "stall");
    applyStimulus(1'b1, 1'b1, 11, 22, 33, 5, 1'b0, 0, 0);
    applyStimulus(1'b0, 1'b0, 99, 99, 99, 5, 1'b0, 0, 0);
    applyStimulus(1'b0, 1'b0, 98, 98, 98, 5, 1'b0, 0, 0);
    applyStimulus(1'b1, 1'b1, 44, 55, 66, 5, 1'b1, 0, 1);
    applyStimulus(1'b1, 1'b1, 200, 3, 77, 60, 1'b0, 0, 2);
    waitFrameDone("stall");
    checkOutput("stall_out_count", 32'(out_cnt - oc), 32'd3);

    $display("[TB] reset after 5 of 16 pixels");
    startFrame(4, 4, 1'b1, "rst");
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 1'b1, 10 * i, 20 + i, 255 - i, 1, 1'b0, i / 4, i % 4);
    @(negedge CLK);
    #1;
    RESET        = 1'b0;
    pix.IN_VALID = 1'b0;
    #1;
    checkResetOutputs("mid_reset");
    sb.delete();
    fd = frame_done_cnt;
    oc = out_cnt;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    idleCycles(6);
    checkOutput("rst_no_out_after_reset", 32'(out_cnt - oc), 32'd0);
    checkOutput("rst_no_frame_done", 32'(frame_done_cnt - fd), 32'd0);
    startFrame(2, 1, 1'b1, "restart");
    applyStimulus(1'b1, 1'b1, 1, 2, 3, 0, 1'b0, 0, 0);
    applyStimulus(1'b1, 1'b1, 4, 5, 6, 0, 1'b0, 0, 1);
    waitFrameDone("restart");

    $display("[TB] zero dimensions and START during RUN");
    oc = out_cnt;
    fd = frame_done_cnt;
    startFrame(0, 3, 1'b0, "w0");
    applyStimulus(1'b1, 1'b0, 7, 7, 7, 0, 1'b0, 0, 0);
    idleCycles(3);
    checkOutput("w0_busy_stays_low", 32'(BUSY), 32'd0);
    startFrame(3, 0, 1'b0, "h0");
    idleCycles(3);
    checkOutput("h0_busy_stays_low", 32'(BUSY), 32'd0);
    checkOutput("zero_dim_no_output", 32'(out_cnt - oc), 32'd0);
    checkOutput("zero_dim_no_frame_done", 32'(frame_done_cnt - fd), 32'd0);
    startFrame(2, 2, 1'b1, "rerun");
    applyStimulus(1'b1, 1'b1, 30, 40, 50, 2, 1'b0, 0, 0);
    START  = 1'b1;
    WIDTH  = 12'd1;
    HEIGHT = 12'd1;
    applyStimulus(1'b1, 1'b1, 31, 41, 51, 2, 1'b1, 0, 1);
    START = 1'b0;
    applyStimulus(1'b1, 1'b1, 32, 42, 52, 3, 1'b0, 1, 0);
    applyStimulus(1'b1, 1'b1, 33, 43, 53, 3, 1'b1, 1, 1);
    waitFrameDone("rerun");

    $display("[TB] oversize frame clamped to 4x4");
    startFrame(9, 5, 1'b1, "clamp");
    for (int i = 0; i < 16; i++)
      applyStimulus(1'b1, 1'b1, int'($urandom_range(255)), int'($urandom_range(255)),
                    int'($urandom_range(255)), int'($urandom_range(255)), 1'(i % 2), i / 4, i % 4);
    waitFrameDone("clamp");

`ifdef PIXEL_ADJUST_GRAYSCALE_EN
    $display("[TB] grayscale mode");
    GRAY_MODE = 1'b1;
    startFrame(2, 1, 1'b1, "gray");
    applyStimulus(1'b1, 1'b1, 100, 200, 40, 0, 1'b0, 0, 0);
    applyStimulus(1'b1, 1'b1, 250, 250, 250, 20, 1'b0, 0, 1);
    waitFrameDone("gray");
    GRAY_MODE = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
